req_issue_ctrl: RTL
===================

# req_issue_ctrl

Requester-side controller for the 4-channel priority grant interface: it queues per-channel request pulses in saturating pending counters, drives `req`/`en` toward the priority selector, and consumes the returned one-hot `gnt`. Each accepted grant occupies the shared resource for a fixed number of cycles, after which the block pulses `done` for that channel. It sits between the four request sources and the priority selector, and owns all sequencing that the combinational selector lacks.

## Interface
- `NUM_CH`, 4: number of channels; fixed to 4 to match the selector.
- `CNT_W`, 3: width of each pending counter; maximum count is 2^CNT_W−1.
- `HOLD_CYCLES`, 2: cycles a granted channel occupies the resource; legal range is ≥1.

- `clock`: in, 1. Single clock domain; all state updates on the rising edge.
- `reset`: in, 1. Asynchronous, active-high.
- `en_in`: in, 1. Global enable; when low, no new grants are accepted.
- `push`: in, 4. Per-channel new-request pulse; one request per set bit per cycle.
- `req`: out, 4. Request mask to the selector.
- `en`: out, 1. Enable to the selector.
- `gnt`: in, 4. Grant from the selector, combinational within the same cycle as `req`/`en`.
- `busy`: out, 1. High while a transaction occupies the resource.
- `done`: out, 4. One-cycle pulse on the final busy cycle of the granted channel.
- `pend_cnt`: out, 4×CNT_W. Current pending counts, channel 0 in the LSBs.
- `overflow`: out, 4. Sticky per-channel flag; set when a push arrives at a saturated counter.
- `proto_err`: out, 1. Sticky; set on an illegal grant.

## Operation
- Reset values: all counters are 0; state is IDLE; `req`, `en`, `busy`, `done`, `overflow`, and `proto_err` are all 0.
- States:
  - IDLE: `req[i]` = (`pend_cnt[i]` != 0); `en` = `en_in` & |`req`.
  - BUSY: `req` = 0, `en` = 0, and `busy` = 1. A hold counter loads HOLD_CYCLES−1 on entry and decrements each cycle.
- IDLE→BUSY: when `en` = 1 and `gnt` is a legal grant. A legal grant is one-hot and targets a channel with a nonzero count. On this transition:
  - latch the channel index;
  - decrement that channel's counter.
- BUSY→IDLE: on the cycle the hold counter reads 0. That same cycle, `done[ch]` = 1.
- Illegal `gnt` while `en` = 1 (zero, multi-hot, or targeting a channel with count 0): set `proto_err`, take no grant, remain IDLE. A nonzero `gnt` while `en` = 0 also sets `proto_err`.
- Counter update per channel each cycle is count + push − granted:
  - push and grant on the same channel in the same cycle leave the count unchanged;
  - push at maximum count with no grant leaves the count at maximum and sets `overflow[i]`;
  - a push is never lost when a grant decrements the counter in the same cycle.
- Pushes are accepted in every state, including BUSY.
- `en_in` low in IDLE: `en` = 0 and counts are held. `en_in` has no effect in BUSY; the transaction always completes.
- Asynchronous reset asserted mid-BUSY: returns to IDLE immediately, with no `done` pulse and counts cleared.

## Timing
- A push at cycle t becomes visible in `pend_cnt` and `req` at t+1.
- A grant accepted in cycle t gives `busy` = 1 from t+1 through t+HOLD_CYCLES. `done` pulses at t+HOLD_CYCLES.
- The block is back in IDLE at t+HOLD_CYCLES+1. Minimum grant-to-grant spacing is therefore HOLD_CYCLES+1 cycles.
- `req` and `en` are decoded from registered state and counts only; there is no combinational path from `push` to `req`. `gnt` is sampled in the same cycle it is issued.

## Structure
- Shared package `req_issue_pkg` contains:
  - `NUM_CH`;
  - enum `issue_state_t` {IDLE, BUSY};
  - function `onehot_to_idx` (4→2 bits);
  - function `is_onehot`.
- One sub-module, `pend_counter`: a per-channel saturating up/down counter with an `overflow` flag, instantiated 4 times.
- The selector itself is not instantiated here. The testbench connects this block to the selector instance.

## Test plan
- Single request: push = 4'b0001 at cycle 1 → `req` = 4'b0001 at cycle 2, `gnt` = 4'b0001. `busy` is high for cycles 3–4, `done` = 4'b0001 at cycle 4, `pend_cnt[0]` = 0.
- Priority and drain: push = 4'b1111 once → grants arrive in order ch3, ch2, ch1, ch0, each spaced 3 cycles apart (HOLD_CYCLES = 2). All counts end at 0.
- Saturation: push ch2 for 9 consecutive cycles with `en_in` = 0 → `pend_cnt[2]` = 7 and `overflow[2]` = 1. Then raise `en_in` → exactly 7 `done[2]` pulses.
- Simultaneous push and grant: `pend_cnt[1]` = 1, push[1] asserted in the grant cycle → count stays 1 and a second grant for ch1 follows after the hold.
- Protocol error: force `gnt` = 4'b0011 while `en` = 1 → `proto_err` = 1, state stays IDLE, counts unchanged.
- Reset mid-BUSY: assert `reset` in the first busy cycle → `busy`, `done`, and all counts are 0 immediately. No `done` pulse appears after `reset` is released.

Source files
------------

// File: rtl/req_issue_pkg.sv
// Shared types and helpers for the request issue controller.
//   NUM_CH        : channel count, fixed to match the priority selector
//   issue_state_t : controller FSM states
//   onehot_to_idx : one-hot grant vector -> channel index
//   is_onehot     : true when exactly one bit is set
package req_issue_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef enum logic [0:0] {IDLE, BUSY} issue_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [NUM_CH-1:0] v);
    return $countones(v) == 1;
  endfunction

endpackage

// File: rtl/req_issue_ctrl_if.sv
// Bundle between the request sources / priority selector and the issue controller.
//   master : controller side (drives req/en/status, consumes push/en_in/gnt)
//   slave  : environment side (request sources plus selector)
interface req_issue_ctrl_if #(
  parameter int unsigned CNT_W = 3
);
  import req_issue_pkg::*;

  logic                    en_in;
  logic [NUM_CH-1:0]       push;
  logic [NUM_CH-1:0]       req;
  logic                    en;
  logic [NUM_CH-1:0]       gnt;
  logic                    busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH*CNT_W-1:0] pend_cnt;
  logic [NUM_CH-1:0]       overflow;
  logic                    proto_err;

  modport master (
    input  en_in, push, gnt,
    output req, en, busy, done, pend_cnt, overflow, proto_err
  );

  modport slave (
    output en_in, push, gnt,
    input  req, en, busy, done, pend_cnt, overflow, proto_err
  );

endinterface

// File: rtl/pend_counter.sv
// Per-channel saturating pending-request counter.
//   clock, reset : clock and asynchronous active-high reset
//   inc          : new request this cycle
//   dec          : request granted this cycle (only issued when cnt is nonzero)
//   cnt          : current pending count
//   overflow     : sticky, set when inc hits a saturated counter with no dec
module pend_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             overflow
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    // inc together with dec cancels, so a push is never lost to a grant
    if (inc && !dec) begin
      if (cnt_q == '1) ovf_d = 1'b1;
      else             cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt      = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/req_issue_ctrl.sv
// Requester-side controller for the 4-channel priority selector. Queues request
// pulses per channel, presents req/en to the selector, accepts a legal one-hot gnt,
// then holds the shared resource for HOLD_CYCLES cycles and pulses done.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : master modport (en_in, push, gnt in; req, en, busy, done,
//                  pend_cnt, overflow, proto_err out)
module req_issue_ctrl
  import req_issue_pkg::*;
#(
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  req_issue_ctrl_if.master bus
);

  localparam int unsigned      HoldW    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

  issue_state_t      state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [1:0]        ch_q, ch_d;
  logic              proto_err_q, proto_err_d;

  logic [CNT_W-1:0]        cnt [NUM_CH];
  logic [NUM_CH-1:0]       nonzero;
  logic [NUM_CH-1:0]       take;
  logic [NUM_CH-1:0]       ovf;
  logic [NUM_CH*CNT_W-1:0] pend_flat;

  logic              en_int, busy_int, grant_ok;
  logic [NUM_CH-1:0] req_int, done_int;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pend_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc     (bus.push[i]),
      .dec     (take[i]),
      .cnt     (cnt[i]),
      .overflow(ovf[i])
    );
    assign nonzero[i]                  = (cnt[i] != '0);
    assign pend_flat[i*CNT_W +: CNT_W] = cnt[i];
  end

  // en is only ever high in IDLE, so req already equals the nonzero-count mask there
  assign grant_ok = en_int && is_onehot(bus.gnt) && ((bus.gnt & nonzero) != '0);
  assign take     = grant_ok ? bus.gnt : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      ch_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      ch_q        <= ch_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d = BUSY;
          hold_d  = HoldLoad;
          ch_d    = onehot_to_idx(bus.gnt);
        end
      end
      BUSY: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - HoldW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Any grant while en is low is a selector fault, as is a bad grant while en is high
    proto_err_d = proto_err_q | (en_int ? !grant_ok : (bus.gnt != '0));
  end

  always_comb begin
    req_int  = '0;
    en_int   = 1'b0;
    busy_int = 1'b0;
    done_int = '0;
    unique case (state_q)
      IDLE: begin
        req_int = nonzero;
        en_int  = bus.en_in & (|nonzero);
      end
      BUSY: begin
        busy_int = 1'b1;
        if (hold_q == '0) done_int[ch_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.req       = req_int;
  assign bus.en        = en_int;
  assign bus.busy      = busy_int;
  assign bus.done      = done_int;
  assign bus.pend_cnt  = pend_flat;
  assign bus.overflow  = ovf;
  assign bus.proto_err = proto_err_q;

endmodule
